// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - UART program loader: 8N1 bytes -> little-endian 32-bit memory writes.
// Optional 8E1 framing when UPG_PARITY_EN is defined.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 101,
  parameter int ADDR_W       = 14,
  parameter int WORD_COUNT   = 16384,
  parameter int IDLE_BITS    = 32
) (
  input  logic              fpga_clk,
  input  logic              fpga_rst,
  input  logic              start_pg,
  input  logic              rx,
  output logic              upg_wen,
  output logic [ADDR_W-1:0] upg_adr,
  output logic [31:0]       upg_dat,
  output logic              upg_active,
  output logic              upg_done,
  output logic              frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int IW = $clog2(IDLE_BITS + 1);
  localparam logic [CW-1:0]     HALF     = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0]     FULL     = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0]     IDLE_MAX = IW'(IDLE_BITS);
  localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(WORD_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UPG_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } rx_state_e;

  logic rx_meta_q, rx_sync_q, rx_prev_q;
  logic st_meta_q, st_sync_q, st_prev_q;

  rx_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        byte_vld_q;
  logic        byte_err_q;
`ifdef UPG_PARITY_EN
  logic        par_ok_q;
`endif

  logic              active_q, done_q, ferr_q, wen_q;
  logic [ADDR_W-1:0] adr_q;
  logic [31:0]       dat_q;
  logic [31:0]       word_q;
  logic [1:0]        idx_q;
  logic              got_q, pend_q, last_q;
  logic [CW-1:0]     icnt_q;
  logic [IW-1:0]     ibits_q;

  logic        start_edge, restart, timeout;
  logic [31:0] word_d;

  always_ff @(posedge fpga_clk or posedge fpga_rst) begin
    if (fpga_rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      st_meta_q <= 1'b0;
      st_sync_q <= 1'b0;
      st_prev_q <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      st_meta_q <= start_pg;
      st_sync_q <= st_meta_q;
      st_prev_q <= st_sync_q;
    end
  end

  always_ff @(posedge fpga_clk or posedge fpga_rst) begin
    if (fpga_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      byte_vld_q <= 1'b0;
      byte_err_q <= 1'b0;
`ifdef UPG_PARITY_EN
      par_ok_q   <= 1'b0;
`endif
    end else begin
      byte_vld_q <= 1'b0;
      byte_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            state_q <= S_START;
            cnt_q   <= '0;
          end
        end
        S_START: begin
          if (cnt_q == HALF) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= rx_sync_q ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == FULL) begin
            cnt_q   <= '0;
            shift_q <= {rx_sync_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef UPG_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
`ifdef UPG_PARITY_EN
        S_PARITY: begin
          if (cnt_q == FULL) begin
            cnt_q    <= '0;
            par_ok_q <= ~(^{shift_q, rx_sync_q});
            state_q  <= S_STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
`endif
        S_STOP: begin
          if (cnt_q == FULL) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
`ifdef UPG_PARITY_EN
            if (rx_sync_q && par_ok_q) byte_vld_q <= 1'b1;
`else
            if (rx_sync_q) byte_vld_q <= 1'b1;
`endif
            else byte_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // A restart that collides with a write strobe is held one cycle so the write lands first.
  always_comb begin
    start_edge = st_sync_q & ~st_prev_q;
    restart    = (start_edge | pend_q) & ~wen_q;
    timeout    = active_q & got_q & (state_q == S_IDLE) & (ibits_q == IDLE_MAX);
    word_d     = word_q;
    case (idx_q)
      2'd0:    word_d[7:0]   = shift_q;
      2'd1:    word_d[15:8]  = shift_q;
      2'd2:    word_d[23:16] = shift_q;
      default: word_d[31:24] = shift_q;
    endcase
  end

  always_ff @(posedge fpga_clk or posedge fpga_rst) begin
    if (fpga_rst) begin
      active_q <= 1'b0;
      done_q   <= 1'b0;
      ferr_q   <= 1'b0;
      wen_q    <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      word_q   <= '0;
      idx_q    <= '0;
      got_q    <= 1'b0;
      pend_q   <= 1'b0;
      last_q   <= 1'b0;
      icnt_q   <= '0;
      ibits_q  <= '0;
    end else begin
      wen_q <= 1'b0;
      if (start_edge && wen_q) pend_q <= 1'b1;
      if (restart) begin
        pend_q   <= 1'b0;
        active_q <= 1'b1;
        done_q   <= 1'b0;
        ferr_q   <= 1'b0;
        adr_q    <= '0;
        idx_q    <= '0;
        word_q   <= '0;
        got_q    <= 1'b0;
        last_q   <= 1'b0;
        icnt_q   <= '0;
        ibits_q  <= '0;
      end else begin
        if (wen_q) begin
          adr_q <= (adr_q == LAST_ADR) ? '0 : adr_q + ADDR_W'(1);
          if (last_q || adr_q == LAST_ADR) begin
            active_q <= 1'b0;
            done_q   <= 1'b1;
            last_q   <= 1'b0;
          end
        end
        if (active_q && !last_q) begin
          if (byte_err_q) ferr_q <= 1'b1;
          if (byte_vld_q) begin
            got_q <= 1'b1;
            if (idx_q == 2'd3) begin
              dat_q  <= word_d;
              wen_q  <= 1'b1;
              word_q <= '0;
              idx_q  <= '0;
            end else begin
              word_q <= word_d;
              idx_q  <= idx_q + 2'd1;
            end
          end
          if (timeout) begin
            got_q <= 1'b0;
            if (idx_q != 2'd0) begin
              dat_q  <= word_q;
              wen_q  <= 1'b1;
              last_q <= 1'b1;
              word_q <= '0;
              idx_q  <= '0;
            end else begin
              active_q <= 1'b0;
              done_q   <= 1'b1;
            end
          end
          if (state_q == S_IDLE && got_q) begin
            if (icnt_q == FULL) begin
              icnt_q <= '0;
              if (ibits_q != IDLE_MAX) ibits_q <= ibits_q + IW'(1);
            end else begin
              icnt_q <= icnt_q + CW'(1);
            end
          end else begin
            icnt_q  <= '0;
            ibits_q <= '0;
          end
        end
      end
    end
  end

  assign upg_wen    = wen_q;
  assign upg_adr    = adr_q;
  assign upg_dat    = dat_q;
  assign upg_active = active_q;
  assign upg_done   = done_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - self-checking bench for uart_prog_loader against a byte-list session model.
module tb_uart_prog_loader;
  localparam int CLKS = 48;
  localparam int AW   = 4;
  localparam int WC   = 4;
  localparam int IB   = 32;

  logic          fpga_clk = 1'b0;
  logic          fpga_rst = 1'b1;
  logic          start_pg = 1'b0;
  logic          rx       = 1'b1;
  logic          upg_wen;
  logic [AW-1:0] upg_adr;
  logic [31:0]   upg_dat;
  logic          upg_active;
  logic          upg_done;
  logic          frame_err;

  int checks = 0;
  int errors = 0;

  logic [AW+31:0] got_q[$];
  logic [AW+31:0] exp_q[$];
  logic [7:0]     m_bytes[$];
  int             m_adr;

  always #5 fpga_clk = ~fpga_clk;

  uart_prog_loader #(.CLKS_PER_BIT(CLKS), .ADDR_W(AW), .WORD_COUNT(WC), .IDLE_BITS(IB)) dut (
    .fpga_clk(fpga_clk), .fpga_rst(fpga_rst), .start_pg(start_pg), .rx(rx),
    .upg_wen(upg_wen), .upg_adr(upg_adr), .upg_dat(upg_dat),
    .upg_active(upg_active), .upg_done(upg_done), .frame_err(frame_err)
  );

  always @(negedge fpga_clk) if (upg_wen === 1'b1) got_q.push_back({upg_adr, upg_dat});

  // Reference model: a session is a list of accepted bytes; every 4 form one word.
  task automatic m_reset();
    m_bytes.delete();
    exp_q.delete();
    m_adr = 0;
  endtask

  task automatic m_flush();
    logic [31:0] w;
    w = 32'h0;
    for (int i = 0; i < m_bytes.size(); i++) w[8*i +: 8] = m_bytes[i];
    exp_q.push_back({AW'(m_adr), w});
    m_bytes.delete();
    m_adr = (m_adr + 1) % WC;
  endtask

  task automatic m_byte(input logic [7:0] b);
    m_bytes.push_back(b);
    if (m_bytes.size() == 4) m_flush();
  endtask

  task automatic m_timeout();
    if (m_bytes.size() != 0) m_flush();
  endtask

  task automatic wait_bits(input int n);
    repeat (n * CLKS) @(posedge fpga_clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CLKS) @(posedge fpga_clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UPG_PARITY_EN
    send_bit(^b);
`endif
    send_bit(stop);
    send_bit(1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1);
    m_byte(b);
  endtask

  task automatic pulse_start();
    start_pg = 1'b1;
    repeat (4) @(posedge fpga_clk);
    start_pg = 1'b0;
    repeat (4) @(posedge fpga_clk);
    m_reset();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge fpga_clk);
    @(negedge fpga_clk);
    checks++; if (upg_wen !== 1'b0) begin errors++; $display("FAIL rst_wen: got %b, expected 0", upg_wen); end
    checks++; if (upg_adr !== '0) begin errors++; $display("FAIL rst_adr: got %h, expected 0", upg_adr); end
    checks++; if (upg_dat !== 32'h0) begin errors++; $display("FAIL rst_dat: got %h, expected 0", upg_dat); end
    checks++; if (upg_active !== 1'b0) begin errors++; $display("FAIL rst_active: got %b, expected 0", upg_active); end
    checks++; if (upg_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b, expected 0", upg_done); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_ferr: got %b, expected 0", frame_err); end
    fpga_rst = 1'b0;
    repeat (3) @(posedge fpga_clk);
  endtask

  task automatic test_basic_word();
    logic [AW+31:0] want;
    got_q.delete();
    pulse_start();
    @(negedge fpga_clk);
    checks++; if (upg_active !== 1'b1 || upg_done !== 1'b0) begin errors++; $display("FAIL t1_start: got active=%b done=%b, expected 1/0", upg_active, upg_done); end
    send_byte(8'h03); send_byte(8'h2A); send_byte(8'h00); send_byte(8'h00);
    @(negedge fpga_clk);
    want = {AW'(0), 32'h00002A03};
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL t1_count: got %0d writes, expected 1", got_q.size()); end
    else if (got_q[0] !== want) begin errors++; $display("FAIL t1_write: got %h, expected %h", got_q[0], want); end
    checks++; if (upg_adr !== AW'(1)) begin errors++; $display("FAIL t1_adr_inc: got %h, expected 1", upg_adr); end
  endtask

  task automatic test_timeout_full();
    got_q.delete();
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(8'h11 + 8'(i));
    m_timeout();
    wait_bits(27);
    @(negedge fpga_clk);
    checks++; if (upg_done !== 1'b0 || upg_active !== 1'b1) begin errors++; $display("FAIL t2_early: got done=%b active=%b, expected 0/1", upg_done, upg_active); end
    wait_bits(6);
    @(negedge fpga_clk);
    checks++; if (upg_done !== 1'b1 || upg_active !== 1'b0) begin errors++; $display("FAIL t2_done: got done=%b active=%b, expected 1/0", upg_done, upg_active); end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL t2_count: got %0d writes, expected %0d", got_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL t2_write%0d: got %h, expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_padded();
    got_q.delete();
    pulse_start();
    send_byte(8'hAB); send_byte(8'hCD);
    m_timeout();
    wait_bits(36);
    @(negedge fpga_clk);
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL t3_count: got %0d writes, expected 1", got_q.size()); end
    else if (got_q[0] !== {AW'(0), 32'h0000CDAB}) begin errors++; $display("FAIL t3_write: got %h, expected %h", got_q[0], {AW'(0), 32'h0000CDAB}); end
    checks++; if (upg_done !== 1'b1 || upg_active !== 1'b0) begin errors++; $display("FAIL t3_done: got done=%b active=%b, expected 1/0", upg_done, upg_active); end
    checks++; if (upg_adr !== AW'(m_adr)) begin errors++; $display("FAIL t3_adr: got %h, expected %h", upg_adr, AW'(m_adr)); end
  endtask

  task automatic test_frame_err();
    got_q.delete();
    pulse_start();
    send_frame(8'hA5, 1'b0);
    @(negedge fpga_clk);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL t4_ferr: got %b, expected 1", frame_err); end
    for (int i = 0; i < 4; i++) send_byte(8'h55);
    @(negedge fpga_clk);
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL t4_count: got %0d writes, expected 1", got_q.size()); end
    else if (got_q[0] !== {AW'(0), 32'h55555555}) begin errors++; $display("FAIL t4_write: got %h, expected %h", got_q[0], {AW'(0), 32'h55555555}); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL t4_sticky: got %b, expected 1", frame_err); end
  endtask

  task automatic test_glitch_and_reset();
    got_q.delete();
    pulse_start();
    rx = 1'b0;
    repeat (20) @(posedge fpga_clk);
    rx = 1'b1;
    wait_bits(36);
    @(negedge fpga_clk);
    checks++; if (got_q.size() != 0 || frame_err !== 1'b0) begin errors++; $display("FAIL t5_glitch: got %0d writes ferr=%b, expected 0/0", got_q.size(), frame_err); end
    checks++; if (upg_active !== 1'b1 || upg_done !== 1'b0) begin errors++; $display("FAIL t5_no_timeout: got active=%b done=%b, expected 1/0", upg_active, upg_done); end
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    rx = 1'b0;
    wait_bits(3);
    #2 fpga_rst = 1'b1;
    #1;
    checks++;
    if ({upg_wen, upg_adr, upg_dat, upg_active, upg_done, frame_err} !== '0) begin
      errors++; $display("FAIL t5_async_rst: got adr=%h dat=%h act=%b done=%b, expected all 0", upg_adr, upg_dat, upg_active, upg_done);
    end
    rx = 1'b1;
    repeat (5) @(posedge fpga_clk);
    #2 fpga_rst = 1'b0;
    repeat (5) @(posedge fpga_clk);
    got_q.delete();
    for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1'b1);
    @(negedge fpga_clk);
    checks++; if (got_q.size() != 0 || upg_active !== 1'b0 || upg_done !== 1'b0) begin
      errors++; $display("FAIL t5_outside: got %0d writes act=%b done=%b, expected 0/0/0", got_q.size(), upg_active, upg_done);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 2; it++) begin
      int n;
      got_q.delete();
      pulse_start();
      n = $urandom_range(5, 11);
      for (int i = 0; i < n; i++) send_byte(8'($urandom));
      m_timeout();
      wait_bits(36);
      @(negedge fpga_clk);
      checks++; if (upg_done !== 1'b1) begin errors++; $display("FAIL rnd%0d_done: got %b, expected 1", it, upg_done); end
      checks++;
      if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd%0d_count: got %0d, expected %0d", it, got_q.size(), exp_q.size()); end
      else for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_write%0d: got %h, expected %h", it, i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_complete();
    got_q.delete();
    pulse_start();
    for (int i = 0; i < 4 * WC; i++) send_byte(8'($urandom));
    @(negedge fpga_clk);
    checks++; if (upg_done !== 1'b1 || upg_active !== 1'b0) begin errors++; $display("FAIL cmp_done: got done=%b active=%b, expected 1/0", upg_done, upg_active); end
    checks++; if (upg_adr !== '0) begin errors++; $display("FAIL cmp_adr_wrap: got %h, expected 0", upg_adr); end
    for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1'b1);
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL cmp_count: got %0d, expected %0d", got_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL cmp_write%0d: got %h, expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    got_q.delete();
    pulse_start();
    send_byte(8'h9A); send_byte(8'hBC);
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(8'($urandom));
    @(negedge fpga_clk);
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL b2b_count: got %0d, expected 1", got_q.size()); end
    else if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL b2b_write: got %h, expected %h", got_q[0], exp_q[0]); end
  endtask

`ifdef UPG_PARITY_EN
  task automatic test_parity();
    logic [7:0] b;
    got_q.delete();
    pulse_start();
    b = 8'h07;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge fpga_clk);
    checks++; if (frame_err !== 1'b1 || got_q.size() != 0) begin errors++; $display("FAIL par_bad: got ferr=%b writes=%0d, expected 1/0", frame_err, got_q.size()); end
    for (int i = 0; i < 4; i++) send_byte(8'h07);
    @(negedge fpga_clk);
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL par_count: got %0d, expected 1", got_q.size()); end
    else if (got_q[0] !== {AW'(0), 32'h07070707}) begin errors++; $display("FAIL par_write: got %h, expected %h", got_q[0], {AW'(0), 32'h07070707}); end
  endtask
`endif

  initial begin
    m_reset();
    test_reset();
    test_basic_word();
    test_timeout_full();
    test_padded();
    test_frame_err();
    test_glitch_and_reset();
    test_random();
    test_complete();
    test_back_to_back();
`ifdef UPG_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Serial program-load front end sitting between the board `rx` pin and the instruction/data memory write ports of the CPU.
- Receives 8N1 UART bytes and assembles them little-endian into 32-bit words.
- Emits one single-cycle memory write per word at an auto-incrementing word address.
- Signals `upg_done` when the image is complete so the CPU can be released from program mode.

Parameters:
- CLKS_PER_BIT, 101, fpga_clk cycles per UART bit (11.63 MHz / 115200).
- ADDR_W, 14, width of the word address.
- WORD_COUNT, 16384, number of words that completes a session.
- IDLE_BITS, 32, idle-line bit-times after at least one byte that also completes a session.

Ports:
- fpga_clk  in  1  system clock, rising edge.
- fpga_rst  in  1  asynchronous, active-high reset.
- start_pg  in  1  program-mode request (async button level).
- rx  in  1  UART serial input, idle high.
- upg_wen  out  1  one-cycle write strobe.
- upg_adr  out  ADDR_W  word address for the current write.
- upg_dat  out  32  assembled word.
- upg_active  out  1  session in progress.
- upg_done  out  1  session complete; held until next session or reset.
- frame_err  out  1  sticky: stop bit (or parity) failure seen this session.

Behaviour:
- **Clocking and reset:** one clock. `fpga_rst` asynchronously clears all state. Reset values of every output: `upg_wen`=0, `upg_adr`=0, `upg_dat`=0, `upg_active`=0, `upg_done`=0, `frame_err`=0. Reset mid-byte or mid-session aborts with no write.
- **Synchronisers:** `rx` and `start_pg` each pass through a 2-flop synchroniser. `rx` resets to 1; `start_pg` resets to 0.
- **Session start:** a rising edge of synchronised `start_pg` starts a session. It sets `upg_active`=1, `upg_done`=0, `frame_err`=0, the address counter to 0 and the byte index to 0. A rising edge during an active session restarts the session the same way and discards any partial word.
- **RX FSM states:** IDLE, START, DATA, STOP.
- **IDLE:** a falling edge on synchronised `rx` -> START, bit counter cleared.
- **START:** at CLKS_PER_BIT/2 (integer division), sample `rx`. 0 -> DATA. 1 -> IDLE (glitch rejected, no error).
- **DATA:** sample every CLKS_PER_BIT cycles, 8 samples, LSB first. Then -> STOP.
- **STOP:** sample after CLKS_PER_BIT. 1 -> byte valid. 0 -> byte discarded and `frame_err` set. Both cases -> IDLE.
- **Bytes outside a session:** received and dropped; they do not alter outputs.
- **Word assembly:** byte k (k=0..3) goes into bits [8k+7:8k]. On the 4th valid byte, `upg_dat` takes the full word and `upg_wen` pulses for exactly 1 cycle with the current `upg_adr`. Byte index wraps 3->0.
- **Address:** `upg_adr` increments by 1 on the cycle after each write.
- **Completion:** after the write at address WORD_COUNT-1, the session ends. `upg_adr` wraps to 0, `upg_active`=0, `upg_done`=1.
- **Idle timeout:** an idle counter counts full bit-times while the FSM is in IDLE and ≥1 valid byte has been received this session. It clears on each start edge. On reaching IDLE_BITS the session ends: `upg_active`=0, `upg_done`=1. An incomplete trailing word (byte index ≠0) is zero-padded in its upper bytes and written once before `upg_done` rises.
- **Before first byte:** an active session that has received no byte never times out.
- **Simultaneous events:** a `start_pg` edge in the same cycle as a write strobe gives the write priority. The write completes, then the restart clears state on the next cycle.

Optional Feature:
- Macro: UPG_PARITY_EN.
- Defined: frame is 8E1. The FSM gains a PARITY state between DATA and STOP. A byte whose even parity mismatches is discarded and sets `frame_err`; the stop-bit rule is unchanged.
- Undefined: plain 8N1, no PARITY state, no parity logic.

Test Plan:
1. Reset, pulse `start_pg`, send bytes 0x03,0x2A,0x00,0x00 -> one `upg_wen` pulse with `upg_adr`=0, `upg_dat`=0x00002A03; then `upg_adr`=1.
2. Send 8 bytes 0x11..0x18 -> writes 0x14131211 at adr 0 and 0x18171615 at adr 1; after 32 idle bit-times, `upg_done`=1, `upg_active`=0.
3. Send 0xAB,0xCD then idle -> padded write 0x0000CDAB at adr 0, then `upg_done`=1.
4. Send byte with stop bit 0, then valid 0x55 ×4 -> `frame_err`=1; single write 0x55555555 at adr 0.
5. Line glitch low for 20 cycles -> no byte, no error. Bytes sent before `start_pg` -> no write. Assert `fpga_rst` mid-byte -> all outputs 0 within the same cycle (async).
6. With UPG_PARITY_EN: byte 0x07 with parity bit 0 (wrong) -> discarded, `frame_err`=1. With parity bit 1 -> accepted.
